// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and 3x3 tap geometry for the convolution window sequencer
package conv_pkg;
  localparam int NUM_TAPS = 9;
  localparam int TAP_C = 4;
  localparam int TAP_DR [NUM_TAPS] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int TAP_DC [NUM_TAPS] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_READ   = 3'd1;
  localparam state_t S_WAIT   = 3'd2;
  localparam state_t S_WRITE  = 3'd3;
  localparam state_t S_UPDATE = 3'd4;
  localparam state_t S_FINISH = 3'd5;
endpackage

// File: rtl/conv_window_ctrl_if.sv
// conv_window_ctrl_if: command/RAM handshake bundle; master drives commands, slave is the sequencer
interface conv_window_ctrl_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 12
);
  import conv_pkg::*;
  logic                              i_start;
  logic                              i_opcode;
  logic                              i_stride2;
  logic                              i_validRam;
  logic [NUM_CH*NUM_TAPS*ADDR_W-1:0] o_addrRead;
  logic [NUM_TAPS-1:0]               o_tapValid;
  logic                              o_startRam;
  logic                              o_selRamD0;
  logic [NUM_CH*ADDR_W-1:0]          o_addrWrite;
  logic                              o_wrEnable;
  logic                              o_busy;
  logic                              o_finish;
  logic [ADDR_W-1:0]                 o_localAddr;
  modport master (
    output i_start, i_opcode, i_stride2, i_validRam,
    input  o_addrRead, o_tapValid, o_startRam, o_selRamD0, o_addrWrite,
           o_wrEnable, o_busy, o_finish, o_localAddr
  );
  modport slave (
    input  i_start, i_opcode, i_stride2, i_validRam,
    output o_addrRead, o_tapValid, o_startRam, o_selRamD0, o_addrWrite,
           o_wrEnable, o_busy, o_finish, o_localAddr
  );
endinterface

// File: rtl/conv_tap_addr.sv
// conv_tap_addr: (row, col) -> nine 3x3 tap addresses with zero-pad mask; off-image taps point at the centre
module conv_tap_addr
  import conv_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12,
  parameter int RW     = $clog2(IMG_H) + 1,
  parameter int CW     = $clog2(IMG_W) + 1
) (
  input  logic [RW-1:0]                i_row,
  input  logic [CW-1:0]                i_col,
  output logic [NUM_TAPS*ADDR_W-1:0]   o_addr,
  output logic [NUM_TAPS-1:0]          o_valid
);
  logic [ADDR_W-1:0] w_centre;
  assign w_centre = ADDR_W'(int'(i_row) * IMG_W + int'(i_col));
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    int w_r, w_c;
    assign w_r = int'(i_row) + TAP_DR[k];
    assign w_c = int'(i_col) + TAP_DC[k];
    assign o_valid[k] = (w_r >= 0) && (w_r < IMG_H) && (w_c >= 0) && (w_c < IMG_W);
    assign o_addr[k*ADDR_W +: ADDR_W] = o_valid[k] ? ADDR_W'(w_r * IMG_W + w_c) : w_centre;
  end
endmodule

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: walks the feature map with stride 1/2, issuing a 9-tap read then one write per output pixel
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 12
) (
  input logic             i_clk,
  input logic             i_reset,
  conv_window_ctrl_if.slave bus
);
  localparam int RW = $clog2(IMG_H) + 1;
  localparam int CW = $clog2(IMG_W) + 1;
  state_t                     r_state;
  logic [RW-1:0]              r_row;
  logic [CW-1:0]              r_col;
  logic [ADDR_W-1:0]          r_idx;
  logic                       r_op;
  logic                       r_s2;
  logic [1:0]                 w_step;
  logic [RW-1:0]              w_row_nxt;
  logic [CW-1:0]              w_col_nxt;
  logic                       w_col_wrap;
  logic                       w_row_end;
  logic                       w_act;
  logic [NUM_TAPS*ADDR_W-1:0] w_taps;
  logic [NUM_TAPS-1:0]        w_mask;
  conv_tap_addr #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .RW(RW), .CW(CW)) u_tap (
    .i_row  (r_row),
    .i_col  (r_col),
    .o_addr (w_taps),
    .o_valid(w_mask)
  );
  assign w_step     = r_s2 ? 2'd2 : 2'd1;
  assign w_col_nxt  = r_col + CW'(w_step);
  assign w_row_nxt  = r_row + RW'(w_step);
  assign w_col_wrap = w_col_nxt >= CW'(IMG_W);
  assign w_row_end  = w_row_nxt >= RW'(IMG_H);
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_idx   <= '0;
      r_op    <= 1'b0;
      r_s2    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.i_start) begin
          r_state <= S_READ;
          r_op    <= bus.i_opcode;
          r_s2    <= bus.i_stride2;
          r_row   <= '0;
          r_col   <= '0;
          r_idx   <= '0;
        end
        S_READ:   r_state <= S_WAIT;
        S_WAIT:   if (bus.i_validRam) r_state <= S_WRITE;
        S_WRITE:  r_state <= S_UPDATE;
        S_UPDATE: begin
          r_idx   <= r_idx + ADDR_W'(1);
          r_col   <= w_col_wrap ? '0 : w_col_nxt;
          if (w_col_wrap) r_row <= w_row_nxt;
          r_state <= (w_col_wrap && w_row_end) ? S_FINISH : S_READ;
        end
        default:  r_state <= S_IDLE;
      endcase
    end
  end
  // addresses are only presented while a pixel is in flight; IDLE and FINISH drive zeros
  assign w_act           = (r_state == S_READ) || (r_state == S_WAIT) || (r_state == S_WRITE) || (r_state == S_UPDATE);
  assign bus.o_addrRead  = w_act ? {NUM_CH{w_taps}} : '0;
  assign bus.o_tapValid  = w_act ? w_mask : '0;
  assign bus.o_localAddr = w_act ? w_taps[TAP_C*ADDR_W +: ADDR_W] : '0;
  assign bus.o_addrWrite = w_act ? {NUM_CH{r_idx}} : '0;
  assign bus.o_startRam  = r_state == S_READ;
  assign bus.o_wrEnable  = r_state == S_WRITE;
  assign bus.o_finish    = r_state == S_FINISH;
  assign bus.o_busy      = r_state != S_IDLE;
  assign bus.o_selRamD0  = r_op;
endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
Parametrised 3x3 convolution window sequencer for the feature-map RAM path. Walks an IMG_H x IMG_W map in row/column order with stride 1 or 2, issues nine tap read addresses per output pixel to NUM_CH channel RAMs, and waits for the RAM-valid handshake. It then issues one write per output pixel. Image borders use zero-padding masks instead of linear address wrap.

Parameters:
IMG_W, 64, map width in pixels (power of two, >=4)
IMG_H, 64, map height in pixels (>=4)
NUM_CH, 3, channel RAMs driven in parallel (identical addresses replicated)
ADDR_W, 12, RAM address width; must be >= clog2(IMG_W*IMG_H)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous active-low reset
i_start  in  1  start pulse; sampled only in IDLE
i_opcode  in  1  RAM-bank select; latched at start
i_stride2  in  1  1 = stride 2, 0 = stride 1; latched at start
i_validRam  in  1  read data valid from RAM block
o_addrRead  out  NUM_CH*9*ADDR_W  tap addresses; tap k at bits [k*ADDR_W +: ADDR_W] per channel slice, channel c at slice c
o_tapValid  out  9  per-tap in-image mask (1 = real pixel, 0 = pad with zero)
o_startRam  out  1  one-cycle read request
o_selRamD0  out  1  latched opcode
o_addrWrite  out  NUM_CH*ADDR_W  output-pixel write address, replicated per channel
o_wrEnable  out  1  one-cycle write strobe
o_busy  out  1  high from READ of first pixel until FINISH inclusive
o_finish  out  1  one-cycle done pulse
o_localAddr  out  ADDR_W  current centre address row*IMG_W+col

Behaviour:
- Reset (async, i_reset=0): state IDLE; row, col, out index, latched opcode and stride = 0. All outputs = 0.
- Tap k = (dr+1)*3+(dc+1), with dr,dc in {-1,0,1}. Tap address = (row+dr)*IMG_W+(col+dc).
- Tap out of range (row+dr outside 0..IMG_H-1, or col+dc outside 0..IMG_W-1): o_tapValid[k]=0 and the address is forced to the centre address. Never wraps.
- States: IDLE, READ, WAIT, WRITE, UPDATE, FINISH.
- IDLE: addresses, masks and strobes are 0. On i_start=1: latch opcode and stride, clear counters, go to READ.
- READ: o_startRam=1 for one cycle; go to WAIT.
- WAIT: hold addresses; i_validRam is sampled only here. If i_validRam=1, go to WRITE; otherwise stay. A valid pulse in any other state is ignored.
- WRITE: o_wrEnable=1 for one cycle at o_addrWrite = out index.
- UPDATE: out index += 1. col += S, where S = 2 if stride2 else 1.
  - If col+S >= IMG_W: col=0, row += S.
  - If this was the last pixel (row+S >= IMG_H and col+S >= IMG_W): go to FINISH; otherwise go to READ.
- FINISH: o_finish=1, o_busy=1; addresses are 0; go to IDLE.
- Addresses, mask and o_localAddr are valid and stable from READ through UPDATE of each pixel.
- Minimum 4 cycles per output pixel. Total writes: IMG_W*IMG_H (stride 1) or (IMG_W/2)*(IMG_H/2) (stride 2).
- i_start while busy: ignored. i_opcode/i_stride2 changes mid-frame: no effect.
- Reset mid-frame: immediate return to IDLE; no o_finish; next start restarts at pixel (0,0).
- All address arithmetic is unsigned ADDR_W. Row/col counters are clog2 width plus 1 guard bit so they cannot overflow.

Decomposition:
- Package conv_pkg: state encoding; tap index constants; TAP_DR/TAP_DC offset tables; NUM_TAPS=9.
- One sub-module, conv_tap_addr: combinational (row, col) -> 9 tap addresses + o_tapValid mask, parametrised by IMG_W, IMG_H, ADDR_W. The FSM and counters stay in conv_window_ctrl.

Test Plan:
- Defaults, stride 1, i_validRam=1 in the first WAIT cycle, start at edge t0 -> first o_wrEnable at t0+3. Expect 4096 writes at addresses 0..4095. o_finish occurs exactly once at t0+16385.
- Pixel (0,0) -> o_tapValid=9'h1B0; taps 4,5,7,8 = 0,1,64,65; masked taps = 0.
- Pixel (1,1) -> o_tapValid=9'h1FF; taps 0..8 = 0,1,2,64,65,66,128,129,130.
- Pixel (63,63) -> o_tapValid=9'h01B; taps 0,1,3,4 = 4030,4031,4094,4095.
- Stride 2 -> 1024 writes at addresses 0..1023; the last centre o_localAddr = 4030; o_finish pulses once.
- Other cases:
  - i_validRam held low for 10 WAIT cycles, with a pulse during READ -> no advance until WAIT sees valid.
  - i_start pulsed mid-frame -> ignored.
  - i_reset low mid-frame -> all outputs 0 and no o_finish; restart begins at centre 0.
